// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings,
// default width and the counter-width helper.
package serial_add_ctrl_pkg;

    // Default operand/result width
    localparam int unsigned SA_W_DEFAULT = 8;

    // Controller state encodings (2-bit, encoding 2'd3 is illegal)
    typedef logic [1:0] sa_state_t;
    localparam sa_state_t ST_IDLE = 2'd0;
    localparam sa_state_t ST_RUN  = 2'd1;
    localparam sa_state_t ST_DONE = 2'd2;

    // Bit counter width for a W-bit operation; the counter runs 0..W-1
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/result handshake bundle between a requester and serial_add_ctrl.
interface serial_add_ctrl_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    // Requester side
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    // Adder side
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single 1-bit full-adder cell built from a 3-to-8 minterm decode.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic [7:0] m;

    // Minterm decode on {a,b,ci}, then OR the sum and carry minterm sets
    always_comb begin
        m = '0;
        m[{a, b, ci}] = 1'b1;
        s  = m[1] | m[2] | m[4] | m[7];
        co = m[3] | m[5] | m[6] | m[7];
    end
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder controller. Operands are captured on an accepted
// start, then one bit pair per clock (LSB first) goes through a single shared
// full-adder cell; sum bits shift into the result MSB, carry is held in a flop.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned W = SA_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned   CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    sa_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  opa_q,   opa_d;
    logic [W-1:0]  opb_q,   opb_d;
    logic [W-1:0]  res_q,   res_d;
    logic          carry_q, carry_d;
    logic          cout_q,  cout_d;

    logic          cell_s;
    logic          cell_co;

    // The only adder logic: one cell fed from the operand LSBs and the carry flop
    fa_bit u_fa (
        .a  (opa_q[0]),
        .b  (opb_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                res_d   = {cell_s, res_q[W-1:1]};
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = cell_co;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cout_d  = cell_co;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = res_q;
    assign bus.cout = cout_q;

endmodule
